// File: rtl/overlap_pkg.sv
// Shared defaults and state encoding for the overlap-add datapath.
// Holds the parameter defaults, the two-state encoding and a counter-width helper.
// Used by every file of the overlap_adder slice.
package overlap_pkg;

  localparam int DEF_WORD_WIDTH     = 16;
  localparam int DEF_LANES          = 4;
  localparam int DEF_BEATS_PER_HALF = 128;

  // EMPTY: no previous-window tail buffered; HELD: tail beat sits in the tail register.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/overlap_lane_add.sv
// One signed lane of the overlap add: a + b in W-bit two's complement.
// Latency: combinational.  Backpressure: none, pure datapath.
// OVERLAP_SAT_EN defined: clamp to the signed range and raise ovf; otherwise wrap, ovf stays 0.
module overlap_lane_add
  import overlap_pkg::*;
#(
  parameter int W = DEF_WORD_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

`ifdef OVERLAP_SAT_EN
  logic [W:0] wide;

  // Sign-extended add; the top two bits disagree exactly when the lane overflowed.
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    ovf  = wide[W] ^ wide[W-1];
    sum  = wide[W-1:0];
    if (ovf) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // Modulo-2^W add; wrapping is the intended behaviour so nothing is flagged.
  always_comb begin
    sum = a + b;
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/overlap_adder.sv
// Overlap-add of a buffered previous-window tail beat with the current-window head beat.
// Latency: 1 cycle from a head load to outValid; a tail load produces no output.
// Backpressure: dataOut held until outAck; a head arriving while a result is unaccepted is dropped and flags protoErr (OVERLAP_SAT_EN selects saturating lanes).
module overlap_adder
  import overlap_pkg::*;
#(
  parameter int WORD_WIDTH     = DEF_WORD_WIDTH,
  parameter int LANES          = DEF_LANES,
  parameter int BEATS_PER_HALF = DEF_BEATS_PER_HALF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        action,
  input  logic [LANES*WORD_WIDTH-1:0] dataIn,
  input  logic                        outAck,
  output logic [LANES*WORD_WIDTH-1:0] dataOut,
  output logic                        outValid,
  output logic                        blockDone,
  output logic                        protoErr,
  output logic                        satFlag
);

  localparam int DW    = LANES * WORD_WIDTH;
  localparam int CNT_W = cnt_width(BEATS_PER_HALF);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_HALF - 1);

  logic [0:0]       state_q, state_d;
  logic [DW-1:0]    tail_q, tail_d;
  logic [DW-1:0]    data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             block_done_q, block_done_d;
  logic             proto_err_q, proto_err_d;
  logic             sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [DW-1:0]    addend;
  logic [DW-1:0]    lane_sum;
  logic [LANES-1:0] lane_ovf;

  // With no tail buffered the head beat is added to zero, i.e. passed through.
  assign addend = (state_q == ST_HELD) ? tail_q : '0;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    overlap_lane_add #(.W(WORD_WIDTH)) u_add (
      .a   (addend[i*WORD_WIDTH +: WORD_WIDTH]),
      .b   (dataIn[i*WORD_WIDTH +: WORD_WIDTH]),
      .sum (lane_sum[i*WORD_WIDTH +: WORD_WIDTH]),
      .ovf (lane_ovf[i])
    );
  end

  // Next-state: tail capture, result hand-off, beat counting and sticky flags.
  always_comb begin
    state_d      = state_q;
    tail_d       = tail_q;
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q & ~outAck;
    block_done_d = 1'b0;
    proto_err_d  = proto_err_q;
    sat_flag_d   = sat_flag_q;
    beat_cnt_d   = beat_cnt_q;

    if (out_valid_q && outAck) begin
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d   = '0;
        block_done_d = 1'b1;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end

    if (load) begin
      if (!action) begin
        // A second tail before its head replaces the first one.
        tail_d  = dataIn;
        state_d = ST_HELD;
        if (state_q == ST_HELD) proto_err_d = 1'b1;
      end else if (out_valid_q && !outAck) begin
        // Output slot still occupied: the head beat is lost, held state untouched.
        proto_err_d = 1'b1;
      end else begin
        data_out_d  = lane_sum;
        out_valid_d = 1'b1;
        state_d     = ST_EMPTY;
        sat_flag_d  = sat_flag_q | (|lane_ovf);
      end
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      tail_q       <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      block_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
      sat_flag_q   <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      tail_q       <= tail_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      block_done_q <= block_done_d;
      proto_err_q  <= proto_err_d;
      sat_flag_q   <= sat_flag_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign dataOut   = data_out_q;
  assign outValid  = out_valid_q;
  assign blockDone = block_done_q;
  assign protoErr  = proto_err_q;
  // Never set in the wrapping build since the lanes report no overflow there.
  assign satFlag   = sat_flag_q;

endmodule
